// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: default geometry and the
// port B request/response state type.
package dmem_responder_pkg;

    localparam int unsigned DMEM_DEPTH_DEFAULT = 4096;
    localparam logic [31:0] DMEM_BASE_DEFAULT  = 32'h0000_0000;

    typedef enum logic {
        B_IDLE = 1'b0,
        B_RESP = 1'b1
    } dmem_b_state_t;

endpackage

// File: rtl/dmem_tdp_ram.sv
// True dual-port word RAM with per-byte write enables, read-first on each port.
// Contents are never reset so the array can map onto block RAM.
module dmem_tdp_ram #(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [3:0]        a_we,
    input  logic [31:0]       a_wdata,
    output logic [31:0]       a_rdata,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [3:0]        b_we,
    input  logic [31:0]       b_wdata,
    output logic [31:0]       b_rdata
);

    logic [31:0] mem [DEPTH];

    // Both ports share one process; the wrapper never lets them write the same word.
    always_ff @(posedge Clk) begin
        a_rdata <= mem[a_addr];
        b_rdata <= mem[b_addr];
        for (int i = 0; i < 4; i++) begin
            if (a_we[i]) mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
            if (b_we[i]) mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: pipeline port A (1-cycle reads, never stalled) and a
// valid/ready debug/loader port B sharing one byte-writable dual-port RAM.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH     = DMEM_DEPTH_DEFAULT,
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = DMEM_BASE_DEFAULT
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_wr_data,
    input  logic          mem_wr_en,
    input  logic [3:0]    mem_byte_en,
    input  logic          mem_rst,
    output logic [31:0]   mem_rd_data,
    output logic          mem_fault,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic          ld_we,
    input  logic [31:0]   ld_addr,
    input  logic [31:0]   ld_wdata,
    input  logic [3:0]    ld_be,
    output logic          ld_rvalid,
    output logic [31:0]   ld_rdata,
    output logic          ld_err,
    output dmem_b_state_t b_state_dbg
);

    localparam logic [31:0] SPAN = 32'(DEPTH) << 2;

    // Port B handshake: a transfer happens on a clock edge where ld_valid && ld_ready.
    // The master holds ld_* stable while ld_valid && !ld_ready, and may drop ld_valid.
    // ld_rvalid pulses for one cycle after each transfer, carrying ld_rdata/ld_err.

    logic [31:0]       a_off, b_off;
    logic              a_in, b_in;
    logic [ADDR_W-1:0] a_idx, b_idx;
    logic              collision;
    logic              b_xfer;
    logic [3:0]        a_we_lanes, b_we_lanes;
    logic [31:0]       ram_a_rdata, ram_b_rdata;

    dmem_b_state_t state_q, state_d;
    logic          run_q;
    logic          a_valid_q, a_fault_q, b_err_q;

    // Subtracting the base makes below-base addresses wrap high, so one compare covers both bounds.
    assign a_off = mem_addr - BASE_ADDR;
    assign b_off = ld_addr - BASE_ADDR;
    assign a_in  = a_off < SPAN;
    assign b_in  = b_off < SPAN;
    assign a_idx = a_off[ADDR_W+1:2];
    assign b_idx = b_off[ADDR_W+1:2];

    assign collision = ld_valid && a_in && b_in && (a_idx == b_idx) && (mem_wr_en || ld_we);

    always_comb begin
        state_d   = state_q;
        ld_ready  = 1'b0;
        ld_rvalid = 1'b0;
        case (state_q)
            B_IDLE: begin
                ld_ready = run_q && !collision;
                if (ld_valid && ld_ready) state_d = B_RESP;
            end
            B_RESP: begin
                ld_rvalid = 1'b1;
                state_d   = B_IDLE;
            end
            default: state_d = B_IDLE;
        endcase
    end

    assign b_xfer     = ld_valid && ld_ready;
    assign a_we_lanes = (mem_wr_en && a_in) ? mem_byte_en : 4'b0000;
    assign b_we_lanes = (b_xfer && ld_we && b_in) ? ld_be : 4'b0000;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= B_IDLE;
            run_q     <= 1'b0;
            a_valid_q <= 1'b0;
            a_fault_q <= 1'b0;
            b_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= 1'b1;
            a_valid_q <= !mem_rst && a_in;
            a_fault_q <= !mem_rst && !a_in;
            if (b_xfer) b_err_q <= !b_in;
        end
    end

    dmem_tdp_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .Clk     (Clk),
        .a_addr  (a_idx),
        .a_we    (a_we_lanes),
        .a_wdata (mem_wr_data),
        .a_rdata (ram_a_rdata),
        .b_addr  (b_idx),
        .b_we    (b_we_lanes),
        .b_wdata (ld_wdata),
        .b_rdata (ram_b_rdata)
    );

    // The RAM output register has no reset; these qualifiers give the reset-to-zero outputs.
    assign mem_rd_data = a_valid_q ? ram_a_rdata : 32'h0;
    assign mem_fault   = a_fault_q;
    assign ld_rdata    = (ld_rvalid && !b_err_q) ? ram_b_rdata : 32'h0;
    assign ld_err      = ld_rvalid && b_err_q;
    assign b_state_dbg = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized traffic on both
// ports, checked every cycle against a word-array model of the memory.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int          DEPTH  = 4096;
    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam longint      BASE_L = longint'(BASE);

    logic          Clk, Reset_n;
    logic [31:0]   mem_addr, mem_wr_data;
    logic          mem_wr_en, mem_rst;
    logic [3:0]    mem_byte_en;
    logic [31:0]   mem_rd_data;
    logic          mem_fault;
    logic          ld_valid, ld_ready, ld_we;
    logic [31:0]   ld_addr, ld_wdata;
    logic [3:0]    ld_be;
    logic          ld_rvalid, ld_err;
    logic [31:0]   ld_rdata;
    dmem_b_state_t b_state_dbg;

    dmem_responder #(.DEPTH(DEPTH), .ADDR_W(12), .BASE_ADDR(BASE)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
        .mem_byte_en(mem_byte_en), .mem_rst(mem_rst),
        .mem_rd_data(mem_rd_data), .mem_fault(mem_fault),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_be(ld_be),
        .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_err(ld_err),
        .b_state_dbg(b_state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] model [DEPTH];
    logic [31:0] exp_rd, exp_rdata;
    logic        exp_fault, exp_resp, exp_err, exp_run, rdata_chk;
    logic        prev_stall;
    logic [68:0] prev_req;

    function automatic bit in_rng(input logic [31:0] a);
        longint la;
        la = longint'({32'b0, a});
        return (la >= BASE_L) && (la < BASE_L + longint'(DEPTH) * 4);
    endfunction

    function automatic int widx(input logic [31:0] a);
        longint la;
        la = longint'({32'b0, a});
        if (!in_rng(a)) return 0;
        return int'((la - BASE_L) / 4);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    // Compare at mid-cycle, then advance the model across the coming rising edge.
    always @(negedge Clk) begin
        bit a_in, b_in, coll, exp_ready, xfer;
        int a_idx, b_idx;
        if (!Reset_n) begin
            exp_rd = '0; exp_fault = 0; exp_resp = 0; exp_err = 0; exp_run = 0;
            exp_rdata = '0; rdata_chk = 1; prev_stall = 0; prev_req = '0;
        end else begin
            a_in  = in_rng(mem_addr);
            b_in  = in_rng(ld_addr);
            a_idx = widx(mem_addr);
            b_idx = widx(ld_addr);
            coll  = ld_valid && a_in && b_in && (a_idx == b_idx) && (mem_wr_en || ld_we);
            exp_ready = exp_run && !exp_resp && !coll;

            check("mem_rd_data", mem_rd_data, exp_rd);
            check("mem_fault", 32'(mem_fault), 32'(exp_fault));
            check("ld_ready", 32'(ld_ready), 32'(exp_ready));
            check("ld_rvalid", 32'(ld_rvalid), 32'(exp_resp));
            check("ld_err", 32'(ld_err), 32'(exp_resp && exp_err));
            if (!exp_resp || rdata_chk)
                check("ld_rdata", ld_rdata, exp_resp ? exp_rdata : 32'h0);
            check("b_state", 32'(b_state_dbg), exp_resp ? 32'(B_RESP) : 32'(B_IDLE));
            if (prev_stall && ld_valid)
                check("ld_hold", 32'({ld_we, ld_addr, ld_wdata, ld_be} == prev_req), 32'd1);
            prev_stall = ld_valid && !exp_ready;
            prev_req   = {ld_we, ld_addr, ld_wdata, ld_be};

            xfer      = ld_valid && exp_ready;
            exp_rd    = mem_rst ? 32'h0 : (a_in ? model[a_idx] : 32'h0);
            exp_fault = !mem_rst && !a_in;
            if (xfer) begin
                exp_err   = !b_in;
                exp_rdata = b_in ? model[b_idx] : 32'h0;
                rdata_chk = !(ld_we && b_in);
            end
            exp_resp = xfer;
            exp_run  = 1;
            if (mem_wr_en && a_in) model[a_idx] = merge(model[a_idx], mem_wr_data, mem_byte_en);
            if (xfer && ld_we && b_in) model[b_idx] = merge(model[b_idx], ld_wdata, ld_be);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_a(input logic [31:0] addr, input logic [31:0] data,
                         input logic we, input logic [3:0] be);
        mem_addr = addr; mem_wr_data = data; mem_wr_en = we; mem_byte_en = be;
    endtask

    task automatic set_b(input logic v, input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] be);
        ld_valid = v; ld_we = we; ld_addr = addr; ld_wdata = data; ld_be = be;
    endtask

    function automatic logic [31:0] pick_addr();
        int r;
        logic [31:0] w;
        r = $urandom_range(0, 9);
        if (r <= 6)      w = 32'($urandom_range(0, 7));
        else if (r == 7) w = 32'($urandom_range(0, DEPTH - 1));
        else if (r == 8) w = 32'(DEPTH + $urandom_range(0, 7));
        else             w = 32'h3FFF_FFFC;
        return BASE + (w << 2) + 32'($urandom_range(0, 3));
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        bit acc;
        Reset_n = 1'b0;
        mem_rst = 1'b0;
        set_a(32'h0, 32'h0, 1'b0, 4'h0);
        set_b(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(posedge Clk);
        #1;
        check("reset rd_data", mem_rd_data, 32'h0);
        check("reset ld_ready", 32'(ld_ready), 32'd0);
        check("reset ld_rvalid", 32'(ld_rvalid), 32'd0);
        check("reset mem_fault", 32'(mem_fault), 32'd0);
        Reset_n = 1'b1;

        // Bring every word to a known value; read register held clear meanwhile.
        mem_rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            set_a(BASE + 32'(i) * 4, 32'h0, 1'b1, 4'hF);
            tick();
        end
        mem_rst = 1'b0;

        // Full-word write then read-back.
        set_a(32'h10, 32'hDEAD_BEEF, 1'b1, 4'hF); tick();
        set_a(32'h10, 32'h0, 1'b0, 4'h0);         tick();
        @(negedge Clk);
        check("t1 rd_data", mem_rd_data, 32'hDEAD_BEEF);
        check("t1 fault", 32'(mem_fault), 32'd0);
        tick();

        // Single-lane write merges into an existing word.
        set_a(32'h10, 32'h1122_3344, 1'b1, 4'hF); tick();
        set_a(32'h10, 32'h0000_AA00, 1'b1, 4'b0010); tick();
        set_a(32'h10, 32'h0, 1'b0, 4'h0);         tick();
        @(negedge Clk);
        check("t2 rd_data", mem_rd_data, 32'h1122_AA44);
        tick();

        // Out of range read and write, then spot-check word 0 and the last word.
        set_a(32'h4000, 32'h0, 1'b0, 4'h0); tick();
        set_a(32'h4000, 32'hFFFF_FFFF, 1'b1, 4'hF);
        @(negedge Clk);
        check("t3 oor rd_data", mem_rd_data, 32'h0);
        check("t3 oor fault", 32'(mem_fault), 32'd1);
        tick();
        set_a(32'h0, 32'h0, 1'b0, 4'h0); tick();
        set_a(32'h3FFC, 32'h0, 1'b0, 4'h0);
        @(negedge Clk);
        check("t3 word0", mem_rd_data, 32'h0);
        check("t3 word0 fault", 32'(mem_fault), 32'd0);
        tick();
        set_a(32'h10, 32'h0, 1'b0, 4'h0); mem_rst = 1'b1;
        @(negedge Clk);
        check("t3 last word fault", 32'(mem_fault), 32'd0);
        tick();
        mem_rst = 1'b0;
        @(negedge Clk);
        check("mem_rst clears", mem_rd_data, 32'h0);
        tick();

        // Port B write colliding with a port A write to the same word.
        set_a(32'h20, 32'h1234_5678, 1'b1, 4'hF);
        set_b(1'b1, 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF);
        @(negedge Clk);
        check("t4 stall", 32'(ld_ready), 32'd0);
        tick();
        set_a(32'h100, 32'h0, 1'b0, 4'h0);
        @(negedge Clk);
        check("t4 accept", 32'(ld_ready), 32'd1);
        tick();
        set_b(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge Clk);
        check("t4 rvalid", 32'(ld_rvalid), 32'd1);
        tick();
        set_a(32'h20, 32'h0, 1'b0, 4'h0);
        @(negedge Clk);
        check("t4 rvalid pulse", 32'(ld_rvalid), 32'd0);
        tick();
        @(negedge Clk);
        check("t4 final word", mem_rd_data, 32'hCAFE_F00D);
        tick();

        // Read/read on the same word does not stall.
        set_a(32'h10, 32'h0, 1'b0, 4'h0);
        set_b(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        @(negedge Clk);
        check("t5 ready", 32'(ld_ready), 32'd1);
        tick();
        set_b(1'b1, 1'b0, 32'h8000, 32'h0, 4'h0);
        @(negedge Clk);
        check("t5 rdata", ld_rdata, 32'h1122_AA44);
        check("t5 err", 32'(ld_err), 32'd0);
        tick();
        tick();
        set_b(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge Clk);
        check("oor ld_err", 32'(ld_err), 32'd1);
        check("oor ld_rdata", ld_rdata, 32'h0);
        tick();

        // Asynchronous reset while a response is outstanding.
        set_b(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        tick();
        set_b(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check("t6 pre rvalid", 32'(ld_rvalid), 32'd1);
        check("t6 pre rd_data", mem_rd_data, 32'h1122_AA44);
        #2 Reset_n = 1'b0;
        #1;
        check("t6 async rvalid", 32'(ld_rvalid), 32'd0);
        check("t6 async rd_data", mem_rd_data, 32'h0);
        check("t6 async rdata", ld_rdata, 32'h0);
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;
        tick();
        @(negedge Clk);
        check("t6 ready after reset", 32'(ld_ready), 32'd1);
        tick();
        @(negedge Clk);
        check("t6 ram preserved", mem_rd_data, 32'h1122_AA44);

        // Randomized traffic on both ports.
        for (int c = 0; c < 4000; c++) begin
            acc = ld_valid && ld_ready;
            tick();
            set_a(pick_addr(), $urandom, ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)));
            mem_rst = ($urandom_range(0, 15) == 0);
            if (ld_valid && !acc) begin
                if ($urandom_range(0, 7) == 0) ld_valid = 1'b0;
            end else if ($urandom_range(0, 1) == 1) begin
                set_b(1'b1, 1'($urandom_range(0, 1)), pick_addr(), $urandom,
                      4'($urandom_range(0, 15)));
            end else begin
                ld_valid = 1'b0;
            end
            @(negedge Clk);
        end
        tick();
        set_b(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
